truth_table_capture: RTL and testbench
======================================

# truth_table_capture

Synthesizable reader for 3-input/1-output characterization traffic: accepts a stream of stimulus/response samples ({a,b,c} plus observed y), builds the DUT's truth table, tracks coverage of all input combinations, and flags inconsistent responses. It sits on the consuming end of a characterization sweep, turning raw samples into a compact table and a pass/fail verdict.

## Interface
- `N_IN`, default 3: number of DUT inputs; table depth `T = 2**N_IN` (legal 1..4).
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `clear` input 1: synchronous restart; same effect as `rst`.
- `in_valid` input 1: a sample is present.
- `in_ready` output 1: block accepts a sample this cycle.
- `in_vec` input N_IN: stimulus combination, MSB = a.
- `in_y` input 1: DUT response for `in_vec`.
- `table_out` output T: bit `i` = captured y for combination `i`.
- `seen` output T: bit `i` = combination `i` captured at least once.
- `complete` output 1: all T combinations seen, no conflict.
- `conflict` output 1: a combination was observed with two different y values.
- `conflict_idx` output N_IN: combination that caused the conflict.
- `sample_count` output 8: accepted samples, saturating at 255.

## Operation
- States: COLLECT, DONE, ERROR. Reset/clear -> COLLECT.
- Accept = `in_valid && in_ready`. `in_ready` = 1 only in COLLECT.
- COLLECT, accept, `seen[in_vec]`=0: set `seen[in_vec]`, write `table_out[in_vec] = in_y`, increment `sample_count`.
- COLLECT, accept, `seen[in_vec]`=1 and `table_out[in_vec] == in_y`: duplicate; count only, table unchanged.
- COLLECT, accept, `seen[in_vec]`=1 and mismatch: keep first value, latch `conflict_idx = in_vec`, count, go ERROR.
- COLLECT -> DONE when `seen` becomes all ones and no conflict.
- DONE and ERROR are sticky until `rst`/`clear`; `in_valid` ignored there (`in_ready`=0).
- `complete` = (state == DONE); `conflict` = (state == ERROR).
- `sample_count` saturates at 255; never wraps.
- Reset values: `in_ready`=1 (COLLECT), `table_out`=0, `seen`=0, `complete`=0, `conflict`=0, `conflict_idx`=0, `sample_count`=0.

## Timing
- All outputs registered; an accepted sample is reflected in `table_out`/`seen`/`sample_count` the following cycle.
- `complete` asserts, and `in_ready` drops, the cycle after the accept that fills the last `seen` bit.
- `conflict` asserts, and `in_ready` drops, the cycle after the conflicting accept.
- `clear` or `rst` concurrent with `in_valid`: reset wins, sample dropped; outputs at reset values next cycle.
- Reset mid-sweep discards all partial state; no partial completion retained.
- Back-to-back accepts every cycle supported in COLLECT; no bubbles.

## Configuration
- `TT_EXPECT_EN` defined: adds input `expected` (T bits) and output `match` (1 bit). `match` = 1 in DONE when `table_out == expected`, else 0; registered, asserts same cycle as `complete`; reset value 0.
- Not defined: `expected` and `match` ports absent; all other behaviour identical.

## Test plan
- Reset, then 8 samples vec 0..7 with y = 0,1,1,0,1,0,0,1 one per cycle -> `table_out`=8'b1001_0110, `seen`=8'hFF, `complete`=1 one cycle after last accept, `sample_count`=8, `in_ready`=0.
- Vec 3 y=1, then vec 3 y=1, then vecs 0,1,2,4..7 -> no conflict, `sample_count`=9, `complete`=1.
- Vec 5 y=0, then vec 5 y=1 -> `conflict`=1, `conflict_idx`=3'd5, `table_out[5]`=0, `in_ready`=0; further samples ignored, `sample_count` stays 2.
- 7 distinct vecs, then `clear` together with valid vec 7 -> all outputs at reset values, `complete`=0, `sample_count`=0.
- 300 samples of vec 0 y=0 -> `sample_count`=255, no conflict, `complete`=0.
- With `TT_EXPECT_EN`, `expected`=8'h96, sweep as in scenario 1 -> `match`=1; rerun with `expected`=8'h97 -> `match`=0, `complete`=1.

Source files
------------

// File: rtl/truth_table_capture.sv
// Truth-table capture for N_IN-input/1-output characterization samples: builds the table,
// tracks coverage, flags conflicting responses. Optional golden compare via macro TT_EXPECT_EN.
module truth_table_capture #(
    parameter  int N_IN = 3,
    localparam int T    = 1 << N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    input  logic            in_y,
    output logic [T-1:0]    table_out,
    output logic [T-1:0]    seen,
    output logic            complete,
    output logic            conflict,
    output logic [N_IN-1:0] conflict_idx,
    output logic [7:0]      sample_count,
`ifdef TT_EXPECT_EN
    input  logic [T-1:0]    expected,
    output logic            match,
`endif
    output logic [1:0]      dbg_state
);

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only while collecting and does not depend on in_valid.
    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DONE    = 2'd1,
        S_ERROR   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [T-1:0]    r_table;
    logic [T-1:0]    r_seen;
    logic [T-1:0]    w_table_next;
    logic [T-1:0]    w_seen_next;
    logic [T-1:0]    w_onehot;
    logic [N_IN-1:0] r_cidx;
    logic [N_IN-1:0] w_cidx_next;
    logic [7:0]      r_count;
    logic [7:0]      w_count_next;
    logic            w_accept;
    logic            w_hit;
    logic            w_mismatch;
`ifdef TT_EXPECT_EN
    logic            r_match;
`endif

    always_comb begin
        w_state_next = r_state;
        w_table_next = r_table;
        w_seen_next  = r_seen;
        w_cidx_next  = r_cidx;
        w_count_next = r_count;
        w_onehot     = T'(1) << in_vec;
        w_accept     = in_valid && (r_state == S_COLLECT);
        w_hit        = |(r_seen & w_onehot);
        w_mismatch   = (r_table[in_vec] != in_y);

        if (w_accept) begin
            if (r_count != 8'hFF) begin
                w_count_next = r_count + 8'd1;
            end
            if (!w_hit) begin
                w_seen_next  = r_seen | w_onehot;
                w_table_next = in_y ? (r_table | w_onehot) : (r_table & ~w_onehot);
            end else if (w_mismatch) begin
                // First captured value is kept; the offending combination is recorded.
                w_cidx_next  = in_vec;
                w_state_next = S_ERROR;
            end
        end

        if ((w_state_next == S_COLLECT) && (&w_seen_next)) begin
            w_state_next = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= S_COLLECT;
            r_table <= '0;
            r_seen  <= '0;
            r_cidx  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_table <= w_table_next;
            r_seen  <= w_seen_next;
            r_cidx  <= w_cidx_next;
            r_count <= w_count_next;
        end
    end

`ifdef TT_EXPECT_EN
    // Registered from next-state values so it rises together with complete.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_match <= 1'b0;
        end else begin
            r_match <= (w_state_next == S_DONE) && (w_table_next == expected);
        end
    end

    assign match = r_match;
`endif

    assign in_ready     = (r_state == S_COLLECT);
    assign table_out    = r_table;
    assign seen         = r_seen;
    assign complete     = (r_state == S_DONE);
    assign conflict     = (r_state == S_ERROR);
    assign conflict_idx = r_cidx;
    assign sample_count = r_count;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_truth_table_capture.sv
// Self-checking bench for truth_table_capture: vector table plus scoreboarded sequences.
// Build with +define+TT_EXPECT_EN to also exercise the golden-compare output.
module tb_truth_table_capture;

    localparam int W = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_vec = 3'd0;
    logic       in_y = 1'b0;
    logic [7:0] table_out;
    logic [7:0] seen;
    logic       complete;
    logic       conflict;
    logic [2:0] conflict_idx;
    logic [7:0] sample_count;
    logic [1:0] dbg_state;
`ifdef TT_EXPECT_EN
    logic [7:0] expected = 8'h00;
    logic       match;
`endif

    truth_table_capture #(.N_IN(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vec       (in_vec),
        .in_y         (in_y),
        .table_out    (table_out),
        .seen         (seen),
        .complete     (complete),
        .conflict     (conflict),
        .conflict_idx (conflict_idx),
        .sample_count (sample_count),
`ifdef TT_EXPECT_EN
        .expected     (expected),
        .match        (match),
`endif
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: 0 = collecting, 1 = done, 2 = error
    logic [7:0] m_table = 8'h00;
    logic [7:0] m_seen = 8'h00;
    logic [7:0] m_count = 8'h00;
    logic [2:0] m_cidx = 3'd0;
    int         m_state = 0;
`ifdef TT_EXPECT_EN
    logic       m_match = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic       clr;
        logic [2:0] vec;
        logic       y;
        logic [7:0] exp_table;
        logic [7:0] exp_count;
        logic       exp_complete;
        logic       exp_conflict;
        logic [2:0] exp_cidx;
    } vec_t;

    vec_t tv[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_pack();
        return {m_table, m_seen, m_count, (m_state == 1), (m_state == 2), (m_state == 0), m_cidx};
    endfunction

    function automatic logic [W-1:0] dut_pack();
        return {table_out, seen, sample_count, complete, conflict, in_ready, conflict_idx};
    endfunction

    task automatic model_update(input logic v, input logic [2:0] vec, input logic y,
                                input logic clr, input logic rs);
        if (clr || rs) begin
            m_table = 8'h00;
            m_seen  = 8'h00;
            m_count = 8'h00;
            m_cidx  = 3'd0;
            m_state = 0;
        end else if (v && m_state == 0) begin
            if (m_count < 8'd255) m_count = m_count + 8'd1;
            if (!m_seen[vec]) begin
                m_seen[vec]  = 1'b1;
                m_table[vec] = y;
            end else if (m_table[vec] != y) begin
                m_cidx  = vec;
                m_state = 2;
            end
            if (m_state == 0 && m_seen == 8'hFF) m_state = 1;
        end
`ifdef TT_EXPECT_EN
        m_match = (m_state == 1) && (m_table == expected);
`endif
    endtask

    // One clock: drive, predict, push; then pop and compare after the edge.
    task automatic step(input logic v, input logic [2:0] vec, input logic y,
                        input logic clr, input logic rs, input string name);
        logic [W-1:0] e;
        in_valid = v;
        in_vec   = vec;
        in_y     = y;
        clear    = clr;
        rst      = rs;
        model_update(v, vec, y, clr, rs);
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        rst      = 1'b0;
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(dut_pack()), 32'(e));
        end
`ifdef TT_EXPECT_EN
        check({name, "_match"}, 32'(match), 32'(m_match));
`endif
    endtask

    initial begin
        logic [7:0] f;
        logic [2:0] rv;
        int guard;

        tv[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, 3'd0};
        tv[1]  = '{1'b1, 1'b0, 3'd1, 1'b1, 8'h02, 8'd2, 1'b0, 1'b0, 3'd0};
        tv[2]  = '{1'b1, 1'b0, 3'd2, 1'b1, 8'h06, 8'd3, 1'b0, 1'b0, 3'd0};
        tv[3]  = '{1'b1, 1'b0, 3'd3, 1'b0, 8'h06, 8'd4, 1'b0, 1'b0, 3'd0};
        tv[4]  = '{1'b1, 1'b0, 3'd4, 1'b1, 8'h16, 8'd5, 1'b0, 1'b0, 3'd0};
        tv[5]  = '{1'b1, 1'b0, 3'd5, 1'b0, 8'h16, 8'd6, 1'b0, 1'b0, 3'd0};
        tv[6]  = '{1'b1, 1'b0, 3'd6, 1'b0, 8'h16, 8'd7, 1'b0, 1'b0, 3'd0};
        tv[7]  = '{1'b1, 1'b0, 3'd7, 1'b1, 8'h96, 8'd8, 1'b1, 1'b0, 3'd0};
        tv[8]  = '{1'b1, 1'b0, 3'd0, 1'b1, 8'h96, 8'd8, 1'b1, 1'b0, 3'd0};
        tv[9]  = '{1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 3'd0};
        tv[10] = '{1'b1, 1'b0, 3'd5, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, 3'd0};
        tv[11] = '{1'b1, 1'b0, 3'd5, 1'b1, 8'h00, 8'd2, 1'b0, 1'b1, 3'd5};
        tv[12] = '{1'b1, 1'b0, 3'd2, 1'b1, 8'h00, 8'd2, 1'b0, 1'b1, 3'd5};
        tv[13] = '{1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 3'd0};

        // Reset values
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, "reset");
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_table", 32'(table_out), 32'd0);
        check("reset_count", 32'(sample_count), 32'd0);

        // Full sweep, ignored post-done sample, clear, conflict, ignored post-error sample
        for (int i = 0; i < 14; i++) begin
            step(tv[i].v, tv[i].vec, tv[i].y, tv[i].clr, 1'b0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_table", i), 32'(table_out), 32'(tv[i].exp_table));
            check($sformatf("vec%0d_count", i), 32'(sample_count), 32'(tv[i].exp_count));
            check($sformatf("vec%0d_complete", i), 32'(complete), 32'(tv[i].exp_complete));
            check($sformatf("vec%0d_conflict", i), 32'(conflict), 32'(tv[i].exp_conflict));
            check($sformatf("vec%0d_cidx", i), 32'(conflict_idx), 32'(tv[i].exp_cidx));
        end

        // Duplicate consistent sample, then the rest of the sweep
        f = 8'($urandom_range(0, 255));
        f[3] = 1'b1;
        step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, "dup_a");
        step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, "dup_b");
        for (int i = 0; i < 8; i++) begin
            if (i != 3) step(1'b1, 3'(i), f[i], 1'b0, 1'b0, $sformatf("dup_sweep%0d", i));
        end
        check("dup_count", 32'(sample_count), 32'd9);
        check("dup_complete", 32'(complete), 32'd1);
        check("dup_conflict", 32'(conflict), 32'd0);
        check("dup_table", 32'(table_out), 32'(f));
        step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "dup_clear");

        // Clear concurrent with the last valid sample: sample dropped
        for (int i = 0; i < 7; i++) step(1'b1, 3'(i), 1'b1, 1'b0, 1'b0, $sformatf("part%0d", i));
        step(1'b1, 3'd7, 1'b1, 1'b1, 1'b0, "clear_with_valid");
        check("clear_seen", 32'(seen), 32'd0);
        check("clear_complete", 32'(complete), 32'd0);
        check("clear_count", 32'(sample_count), 32'd0);

        // Reset concurrent with valid
        step(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, "pre_rst");
        step(1'b1, 3'd4, 1'b1, 1'b0, 1'b1, "rst_with_valid");
        check("rst_valid_seen", 32'(seen), 32'd0);

        // Saturation
        for (int i = 0; i < 300; i++) step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "sat");
        check("sat_count", 32'(sample_count), 32'd255);
        check("sat_conflict", 32'(conflict), 32'd0);
        check("sat_complete", 32'(complete), 32'd0);
        step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "sat_clear");

        // Random-order sweep of a random function, bounded
        f = 8'($urandom_range(0, 255));
        guard = 0;
        while (m_state == 0 && guard < 200) begin
            rv = 3'($urandom_range(0, 7));
            step(1'b1, rv, f[rv], 1'b0, 1'b0, "rand");
            guard++;
        end
        check("rand_complete", 32'(complete), 32'd1);
        check("rand_table", 32'(table_out), 32'(f));
        step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "rand_clear");

`ifdef TT_EXPECT_EN
        expected = 8'h96;
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), tv[i].y, 1'b0, 1'b0, "m96");
        check("match_96", 32'(match), 32'd1);
        step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "m_clear");
        expected = 8'h97;
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), tv[i].y, 1'b0, 1'b0, "m97");
        check("match_97", 32'(match), 32'd0);
        check("match_97_complete", 32'(complete), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
